// File: rtl/systolic_tile_feeder.sv
// Buffers one A/W operand tile and replays it into the PE cluster as a diagonally
// skewed wavefront: load -> stream -> drain -> done, one tile at a time.
module systolic_tile_feeder #(
  parameter int DIM          = 8,
  parameter int DW           = 16,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DIM*DW-1:0]   i_in_act,
  input  logic [DIM*DW-1:0]   i_in_wgt,
  output logic [DIM*DW-1:0]   o_activations,
  output logic [DIM*DW-1:0]   o_weights,
  output logic [DIM-1:0]      o_done,
  output logic                o_busy,
  output logic                o_tile_done
);

  localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW = $clog2(2 * DIM);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [TW-1:0]       r_t;
  logic [CW-1:0]       r_drain;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_tile_done;
  logic [DIM*DW-1:0]   r_act;
  logic [DIM*DW-1:0]   r_wgt;
  logic [DIM-1:0]      r_done;

  logic                w_load_fire;
  logic [DIM*DW-1:0]   w_act_wave;
  logic [DIM*DW-1:0]   w_wgt_wave;
  logic [DIM-1:0]      w_done_wave;

  assign w_load_fire = (r_state == S_LOAD) && r_in_ready && i_in_valid;

  // Each lane owns its own column: lane i keeps A[i][*], lane j keeps W[*][j].
  // Both are read at step t-lane, which produces the diagonal skew.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    logic [DW-1:0] r_act_mem [DIM];
    logic [DW-1:0] r_wgt_mem [DIM];
    logic [TW-1:0] w_diff;
    logic          w_in_range;

    always_ff @(posedge clk) begin
      if (w_load_fire) begin
        r_act_mem[r_k] <= i_in_act[gi*DW +: DW];
        r_wgt_mem[r_k] <= i_in_wgt[gi*DW +: DW];
      end
    end

    assign w_diff     = r_t - TW'(gi);
    assign w_in_range = (r_t >= TW'(gi)) && (w_diff <= TW'(DIM - 1));

    assign w_act_wave[gi*DW +: DW] = w_in_range ? r_act_mem[w_diff[KW-1:0]] : '0;
    assign w_wgt_wave[gi*DW +: DW] = w_in_range ? r_wgt_mem[w_diff[KW-1:0]] : '0;
    assign w_done_wave[gi]         = w_in_range && (w_diff == TW'(DIM - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_k         <= '0;
      r_t         <= '0;
      r_drain     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_tile_done <= 1'b0;
      r_act       <= '0;
      r_wgt       <= '0;
      r_done      <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_load_fire) begin
            if (r_k == KW'(DIM - 1)) begin
              r_state    <= S_STREAM;
              r_k        <= '0;
              r_t        <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (i_en) begin
            r_act  <= w_act_wave;
            r_wgt  <= w_wgt_wave;
            r_done <= w_done_wave;
            r_t    <= r_t + 1'b1;
            if (r_t == TW'(2 * DIM - 2)) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (i_en) begin
            r_act   <= '0;
            r_wgt   <= '0;
            r_done  <= '0;
            r_drain <= r_drain + 1'b1;
            if (r_drain == CW'(DRAIN_CYCLES - 1)) begin
              r_state     <= S_DONE;
              r_tile_done <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_LOAD;
          r_tile_done <= 1'b0;
          r_k         <= '0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_busy        = r_busy;
  assign o_tile_done   = r_tile_done;
  assign o_activations = r_act;
  assign o_weights     = r_wgt;
  assign o_done        = r_done;

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Directed bench for systolic_tile_feeder: wavefront table, done flags, en stall,
// back-to-back tiles with in_valid held high, and reset in the middle of a stream.
module tb_systolic_tile_feeder;
  localparam int DIM = 8;
  localparam int DW  = 16;
  localparam int BW  = DIM * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_act = '0;
  logic [BW-1:0] in_wgt = '0;
  logic [BW-1:0] out_act;
  logic [BW-1:0] out_wgt;
  logic [DIM-1:0] out_done;
  logic          busy;
  logic          tile_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            t;
    int            a_lane;
    logic [15:0]   a_exp;
    int            w_lane;
    logic [15:0]   w_exp;
    logic [7:0]    d_exp;
  } vec_t;
  vec_t tbl[7];

  systolic_tile_feeder #(.DIM(DIM), .DW(DW), .DRAIN_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_act(in_act), .i_in_wgt(in_wgt), .o_activations(out_act), .o_weights(out_wgt),
    .o_done(out_done), .o_busy(busy), .o_tile_done(tile_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] a_val(logic [15:0] tag, int i, int k);
    return 16'((i << 8) | k) ^ tag;
  endfunction

  function automatic logic [15:0] w_val(logic [15:0] tag, int k, int j);
    return (16'h8000 | 16'((k << 8) | j)) ^ tag;
  endfunction

  function automatic logic [BW-1:0] exp_act(logic [15:0] tag, int t);
    logic [BW-1:0] b = '0;
    for (int i = 0; i < DIM; i++)
      if (t - i >= 0 && t - i < DIM) b[i*DW +: DW] = a_val(tag, i, t - i);
    return b;
  endfunction

  function automatic logic [BW-1:0] exp_wgt(logic [15:0] tag, int t);
    logic [BW-1:0] b = '0;
    for (int j = 0; j < DIM; j++)
      if (t - j >= 0 && t - j < DIM) b[j*DW +: DW] = w_val(tag, t - j, j);
    return b;
  endfunction

  function automatic logic [DIM-1:0] exp_done(int t);
    logic [DIM-1:0] d = '0;
    for (int i = 0; i < DIM; i++)
      if (t - i == DIM - 1) d[i] = 1'b1;
    return d;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives 8 beats starting at the current time; leaves in_valid high with junk data if hold.
  task automatic load_tile(input logic [15:0] tag, input bit hold);
    for (int k = 0; k < DIM; k++) begin
      for (int i = 0; i < DIM; i++) begin
        in_act[i*DW +: DW] = a_val(tag, i, k);
        in_wgt[i*DW +: DW] = w_val(tag, k, i);
      end
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    if (hold) begin
      in_act = {DIM{16'hDEAD}};
      in_wgt = {DIM{16'hBEEF}};
    end else begin
      in_valid = 1'b0;
    end
    $display("load tag=%h hold=%0d done", tag, hold);
  endtask

  task automatic run_tile(input logic [15:0] tag, input int stall_t, input int stall_len,
                          input int abort_t, input bit use_tbl, output int total);
    int after;
    total = 0;
    chk("post_load_busy", BW'(busy), BW'(1));
    chk("post_load_ready", BW'(in_ready), BW'(0));
    for (int t = 0; t < 2 * DIM - 1; t++) begin
      @(posedge clk);
      total++;
      @(negedge clk);
      $display("tag=%h t=%0d act=%h wgt=%h done=%h", tag, t, out_act, out_wgt, out_done);
      chk($sformatf("act_t%0d", t), out_act, exp_act(tag, t));
      chk($sformatf("wgt_t%0d", t), out_wgt, exp_wgt(tag, t));
      chk($sformatf("done_t%0d", t), BW'(out_done), BW'(exp_done(t)));
      if (use_tbl) begin
        foreach (tbl[v]) begin
          if (tbl[v].t == t) begin
            chk($sformatf("tbl%0d_act", v), BW'(out_act[tbl[v].a_lane*DW +: DW]), BW'(tbl[v].a_exp));
            chk($sformatf("tbl%0d_wgt", v), BW'(out_wgt[tbl[v].w_lane*DW +: DW]), BW'(tbl[v].w_exp));
            chk($sformatf("tbl%0d_done", v), BW'(out_done), BW'(tbl[v].d_exp));
          end
        end
      end
      if (t == abort_t) begin
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted mid-stream at t=%0d", t);
        chk("abort_act", out_act, '0);
        chk("abort_wgt", out_wgt, '0);
        chk("abort_done", BW'(out_done), '0);
        chk("abort_ready", BW'(in_ready), BW'(1));
        chk("abort_busy", BW'(busy), BW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        total = -1;
        return;
      end
      if (t == stall_t && stall_len > 0) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk);
          total++;
          @(negedge clk);
          $display("stall cycle %0d at t=%0d act=%h", s, t, out_act);
          chk($sformatf("stall%0d_act", s), out_act, exp_act(tag, t));
          chk($sformatf("stall%0d_busy", s), BW'(busy), BW'(1));
        end
        en = 1'b1;
      end
    end
    after = 0;
    forever begin
      @(posedge clk);
      total++;
      after++;
      @(negedge clk);
      if (after == 1) begin
        chk("drain_act0", out_act, '0);
        chk("drain_wgt0", out_wgt, '0);
        chk("drain_done0", BW'(out_done), '0);
        chk("drain_busy", BW'(busy), BW'(1));
      end
      if (tile_done === 1'b1) break;
      if (after > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tile_done_timeout: got no pulse after %0d cycles, required 16", after);
        break;
      end
    end
    $display("tag=%h tile_done after %0d drain cycles, %0d total", tag, after, total);
    chk("drain_len", BW'(after), BW'(16));
    chk("done_busy", BW'(busy), BW'(0));
    @(posedge clk);
    @(negedge clk);
    chk("pulse_width", BW'(tile_done), BW'(0));
    chk("next_ready", BW'(in_ready), BW'(1));
  endtask

  initial begin
    int tot0, tot1, tot_tmp;
    tbl[0] = '{t: 0,  a_lane: 0, a_exp: 16'h0000, w_lane: 0, w_exp: 16'h8000, d_exp: 8'h00};
    tbl[1] = '{t: 3,  a_lane: 2, a_exp: 16'h0201, w_lane: 2, w_exp: 16'h8102, d_exp: 8'h00};
    tbl[2] = '{t: 6,  a_lane: 7, a_exp: 16'h0000, w_lane: 1, w_exp: 16'h8501, d_exp: 8'h00};
    tbl[3] = '{t: 7,  a_lane: 0, a_exp: 16'h0007, w_lane: 7, w_exp: 16'h8007, d_exp: 8'h01};
    tbl[4] = '{t: 7,  a_lane: 7, a_exp: 16'h0700, w_lane: 0, w_exp: 16'h8700, d_exp: 8'h01};
    tbl[5] = '{t: 10, a_lane: 3, a_exp: 16'h0307, w_lane: 5, w_exp: 16'h8505, d_exp: 8'h08};
    tbl[6] = '{t: 14, a_lane: 7, a_exp: 16'h0707, w_lane: 7, w_exp: 16'h8707, d_exp: 8'h80};

    #12 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-cycle");
    chk("rst_act", out_act, '0);
    chk("rst_wgt", out_wgt, '0);
    chk("rst_done", BW'(out_done), '0);
    chk("rst_ready", BW'(in_ready), BW'(1));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_tile_done", BW'(tile_done), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("idle after reset: ready=%0d busy=%0d", in_ready, busy);
    chk("idle_ready", BW'(in_ready), BW'(1));
    chk("idle_busy", BW'(busy), BW'(0));
    chk("idle_act", out_act, '0);

    load_tile(16'h0000, 1'b0);
    run_tile(16'h0000, -1, 0, -1, 1'b1, tot0);
    chk("total_unstalled", BW'(tot0), BW'(31));

    load_tile(16'h0000, 1'b0);
    run_tile(16'h0000, 4, 5, -1, 1'b1, tot1);
    chk("stall_delay", BW'(tot1 - tot0), BW'(5));

    load_tile(16'h1111, 1'b1);
    run_tile(16'h1111, -1, 0, -1, 1'b0, tot_tmp);
    load_tile(16'h2222, 1'b0);
    run_tile(16'h2222, -1, 0, -1, 1'b0, tot_tmp);

    load_tile(16'h3333, 1'b0);
    run_tile(16'h3333, -1, 0, 6, 1'b0, tot_tmp);
    chk("post_abort_ready", BW'(in_ready), BW'(1));
    load_tile(16'h4444, 1'b0);
    run_tile(16'h4444, -1, 0, -1, 1'b0, tot_tmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_tile_feeder.md
Name: systolic_tile_feeder

Overview:
- Transmit-side driver for the 8x8 PE cluster.
- Buffers one operand tile pair: activation matrix A (DIM lanes x DIM steps) and weight matrix W (DIM steps x DIM lanes).
- Replays the tile into the cluster's activations/weights/done inputs as a diagonally skewed wavefront, so that PE(i,j) sees A[i][k] and W[k][j] together.
- Sequences load -> stream -> drain per tile and signals tile completion to the controller.

Parameters:
- DIM, 8: array dimension; lanes per bus and steps per tile.
- DW, 16: operand width per lane.
- DRAIN_CYCLES, 16: en-qualified idle cycles after the last wavefront before tile_done.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: one clock, asynchronous assert, active-low (decided).
- en  input  1  stream advance enable; same enable that drives the cluster.
- in_valid  input  1  load beat valid.
- in_ready  output  1  load beat accepted when in_valid && in_ready.
- in_act  input  DIM*DW  activation slice k; lane i = bits[i*DW+:DW] = A[i][k].
- in_wgt  input  DIM*DW  weight slice k; lane j = bits[j*DW+:DW] = W[k][j].
- out_activations  output  DIM*DW  to cluster activations, registered.
- out_weights  output  DIM*DW  to cluster weights, registered.
- out_done  output  DIM  to cluster done; bit i marks the last element on lane i.
- busy  output  1  high in STREAM and DRAIN.
- tile_done  output  1  one-cycle pulse at end of DRAIN.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, all counters 0, in_ready=1, out_* =0, busy=0, tile_done=0. Buffer contents are don't-care. Reset mid-tile discards the tile with no partial output.
- States: LOAD, STREAM, DRAIN, DONE.
- LOAD:
  - in_ready=1.
  - Each handshake writes slice k = load counter (0..DIM-1) into both buffers, then increments k.
  - When the handshake with k=DIM-1 occurs, go to STREAM next cycle with t=0.
  - LOAD is not gated by en. Outputs hold 0.
- STREAM:
  - in_ready=0, busy=1.
  - On each edge with en=1, the registers load wavefront t and t increments.
  - Activation lane i = A[i][t-i] if 0 <= t-i <= DIM-1, else 0.
  - Weight lane j = W[t-j][j] if 0 <= t-j <= DIM-1, else 0.
  - out_done[i]=1 exactly when t-i == DIM-1, else 0.
  - After wavefront t=2*DIM-2 (14) is loaded, go to DRAIN with drain counter 0.
  - en=0: outputs, t and state freeze; there is no bubble insertion.
  - Latency: wavefront t is visible on outputs the cycle after the (t+1)-th en-qualified STREAM edge.
- DRAIN:
  - On the first en edge all out_* are cleared to 0.
  - The counter increments per en edge. When it reaches DRAIN_CYCLES, go to DONE.
- DONE:
  - tile_done=1 for exactly one cycle, busy=0.
  - Next state is LOAD with k=0. in_ready is asserted the following cycle.
- The buffer is written only in LOAD, so stream data is never corrupted by in_* activity.
- in_valid during STREAM, DRAIN or DONE is ignored; no data is captured.
- Counter widths: k is clog2(DIM) bits; t is clog2(2*DIM) bits; the drain counter is wide enough for DRAIN_CYCLES. No counter wraps; transitions occur on exact compare.
- Data is passed unmodified; there is no arithmetic on operands.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> out_*=0, in_ready=1, busy=0 immediately. Release and hold in_valid=0 -> state stays LOAD.
- Tile stream:
  - Load 8 beats, in_act lane i of slice k = 16'h{i,k} (e.g. A[2][1]=16'h0201), in_wgt lane j = 16'h8000|{k,j}.
  - Cycle t=0: act lane0=16'h0000, lanes1-7=0, wgt lane0=16'h8000.
  - t=3: act lane2=16'h0201, wgt lane2=16'h8102.
  - t=15 and beyond: all zero.
- Done flags: in the same run, out_done=8'h01 at t=7, 8'h80 at t=14, exactly one bit per cycle for t=7..14, 0 otherwise.
- en stall: drop en for 5 cycles at t=4 -> outputs and busy hold the t=4 values. On resume, t=5 values appear. tile_done arrives 5 cycles later than in the unstalled run.
- Back-to-back and backpressure:
  - tile_done pulses once, 1 cycle, 16 en cycles after the last wavefront.
  - in_valid held high throughout -> only 8 beats accepted per tile. Second tile loads and streams correctly with no stale data.
- Reset mid-STREAM: assert rst_n=0 at t=6 -> outputs 0 asynchronously. After release, in_ready=1 and a fresh tile streams correctly.
